// File: rtl/univ_sreg_pkg.sv
// Shared definitions for the universal shift register.
//   mode_e  : operation select carried on the mode bus
//   state_e : burst engine states
//   sel_e   : per-bit next-value mux select driven into each register cell
package univ_sreg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROTL = 3'b100,
        MODE_ROTR = 3'b101,
        MODE_INV  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // HOLD keeps the bit, PAR takes the parallel input (d or ~q),
    // LO takes the value from the lower neighbour, HI from the upper one.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_PAR  = 2'b01,
        SEL_LO   = 2'b10,
        SEL_HI   = 2'b11
    } sel_e;

    // Modes that can be run as a counted burst.
    function automatic logic is_shift_mode(input mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROTL) || (m == MODE_ROTR);
    endfunction

endpackage

// File: rtl/univ_sreg_if.sv
// Control/data bundle of the universal shift register.
//   master : drives en, mode, d, sil, sir, sclr, spre, burst_start, burst_len
//   slave  : drives q, sol, sor, busy, done, zero
interface univ_sreg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sil;
    logic             sir;
    logic             sclr;
    logic             spre;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] q;
    logic             sol;
    logic             sor;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output en, mode, d, sil, sir, sclr, spre, burst_start, burst_len,
        input  q, sol, sor, busy, done, zero
    );

    modport slave (
        input  en, mode, d, sil, sir, sclr, spre, burst_start, burst_len,
        output q, sol, sor, busy, done, zero
    );
endinterface

// File: rtl/univ_sreg_cell.sv
// One storage bit of the universal shift register.
//   clk, reset (async, active-low) ; sclr/spre synchronous clear/preset
//   sel    : 4:1 next-value select (hold / parallel / lower / upper neighbour)
//   par_in, lo_in, hi_in : candidate next values ; q : stored bit
module univ_sreg_cell
    import univ_sreg_pkg::*;
#(
    parameter logic RESET_BIT  = 1'b0,
    parameter logic PRESET_BIT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sclr,
    input  logic spre,
    input  sel_e sel,
    input  logic par_in,
    input  logic lo_in,
    input  logic hi_in,
    output logic q
);
    logic q_reg;
    logic q_next;

    always_comb begin
        q_next = q_reg;
        case (sel)
            SEL_HOLD: q_next = q_reg;
            SEL_PAR:  q_next = par_in;
            SEL_LO:   q_next = lo_in;
            SEL_HI:   q_next = hi_in;
            default:  q_next = q_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg <= RESET_BIT;
        end else if (sclr) begin
            q_reg <= 1'b0;
        end else if (spre) begin
            q_reg <= PRESET_BIT;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: clear/preset, parallel load, shifts, rotates,
// invert, and a counted burst-shift engine.
//   clk   : rising-edge clock
//   reset : asynchronous reset, active-low
//   bus   : univ_sreg_if slave (control/data in, q/sol/sor/busy/done/zero out)
module univ_shift_reg
    import univ_sreg_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
    parameter int               CNT_W      = 4
) (
    input logic        clk,
    input logic        reset,
    univ_sreg_if.slave bus
);
    state_e           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    mode_e            mode_lat_reg, mode_lat_next;
    logic             done_reg, done_next;

    mode_e            mode_in;
    mode_e            op_mode;
    logic             launch;
    logic             busy;
    sel_e             sel;
    logic             par_inv;
    logic             rot_l;
    logic             rot_r;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] par_in;
    logic [WIDTH-1:0] lo_in;
    logic [WIDTH-1:0] hi_in;

    assign mode_in = mode_e'(bus.mode);
    assign launch  = (state_reg == IDLE) && bus.burst_start && bus.en &&
                     is_shift_mode(mode_in) && (bus.burst_len != '0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            mode_lat_reg <= MODE_HOLD;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            mode_lat_reg <= mode_lat_next;
            done_reg     <= done_next;
        end
    end

    // Next-state logic. Clear/preset abort any burst without a done pulse.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        mode_lat_next = mode_lat_reg;
        done_next     = 1'b0;
        if (bus.sclr || bus.spre) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        mode_lat_next = mode_in;
                        if (bus.burst_len == CNT_W'(1)) begin
                            done_next = 1'b1;
                        end else begin
                            state_next = SHIFT;
                            cnt_next   = bus.burst_len - 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.en) begin
                        cnt_next = cnt_reg - 1'b1;
                        if (cnt_reg == CNT_W'(1)) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic: pick the operation applied to the datapath this cycle and
    // decode it into the shared per-bit mux select.
    always_comb begin
        busy    = (state_reg == SHIFT);
        op_mode = MODE_HOLD;
        if (bus.en) begin
            op_mode = busy ? mode_lat_reg : mode_in;
        end
        sel     = SEL_HOLD;
        par_inv = 1'b0;
        case (op_mode)
            MODE_LOAD:            sel = SEL_PAR;
            MODE_INV:  begin      sel = SEL_PAR; par_inv = 1'b1; end
            MODE_SHL, MODE_ROTL:  sel = SEL_LO;
            MODE_SHR, MODE_ROTR:  sel = SEL_HI;
            default:              sel = SEL_HOLD;
        endcase
        rot_l = (op_mode == MODE_ROTL);
        rot_r = (op_mode == MODE_ROTR);
    end

    // Per-bit neighbour wiring. The end bits take serial input or wrap around;
    // with WIDTH=1 the wrap feeds the bit back to itself, so rotates hold.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign par_in[gi] = par_inv ? ~q[gi] : bus.d[gi];

            if (gi == 0) begin : g_lo_end
                assign lo_in[gi] = rot_l ? q[WIDTH-1] : bus.sil;
            end else begin : g_lo_mid
                assign lo_in[gi] = q[gi-1];
            end

            if (gi == WIDTH-1) begin : g_hi_end
                assign hi_in[gi] = rot_r ? q[0] : bus.sir;
            end else begin : g_hi_mid
                assign hi_in[gi] = q[gi+1];
            end

            univ_sreg_cell #(
                .RESET_BIT  (RESET_VAL[gi]),
                .PRESET_BIT (PRESET_VAL[gi])
            ) u_cell (
                .clk    (clk),
                .reset  (reset),
                .sclr   (bus.sclr),
                .spre   (bus.spre),
                .sel    (sel),
                .par_in (par_in[gi]),
                .lo_in  (lo_in[gi]),
                .hi_in  (hi_in[gi]),
                .q      (q[gi])
            );
        end
    endgenerate

    assign bus.q    = q;
    assign bus.sol  = q[WIDTH-1];
    assign bus.sor  = q[0];
    assign bus.zero = (q == '0);
    assign bus.busy = busy;
    assign bus.done = done_reg;
endmodule
